// File: rtl/upc_pkg.sv
// Shared types and defaults for the microPC sequencer and its SPC return stack.
package upc_pkg;
  localparam int UPC_PC_W     = 14;
  localparam int UPC_SPC_LOG2 = 5;

  typedef enum logic [2:0] {
    ST_DECODE,
    ST_READ,
    ST_ALU,
    ST_WRITE,
    ST_MMU,
    ST_FETCH
  } upc_state_e;

  typedef enum logic [1:0] {
    SRC_INC,
    SRC_JUMP,
    SRC_DISP,
    SRC_SPC
  } pc_src_e;
endpackage

// File: rtl/spc_stack.sv
// SPC return stack: register file plus wrapping pointer with sticky overflow/underflow flags.
module spc_stack
  import upc_pkg::*;
#(
  parameter int PC_W     = UPC_PC_W,
  parameter int SPC_LOG2 = UPC_SPC_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                swap,
  input  logic [PC_W-1:0]     wdata,
  output logic [PC_W-1:0]     top,
  output logic [SPC_LOG2-1:0] ptr,
  output logic                ovf,
  output logic                unf
);
  localparam int DEPTH = 1 << SPC_LOG2;

  logic [PC_W-1:0]     mem_q [DEPTH];
  logic [SPC_LOG2-1:0] ptr_q, ptr_d, waddr;
  logic                ovf_q, ovf_d, unf_q, unf_d, we;

  always_comb begin
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = ptr_q;
    if (push) begin
      ptr_d = ptr_q + SPC_LOG2'(1);
      waddr = ptr_d;
      we    = 1'b1;
      if (&ptr_q) ovf_d = 1'b1;
    end else if (swap) begin
      we = 1'b1;
    end else if (pop) begin
      ptr_d = ptr_q - SPC_LOG2'(1);
      if (ptr_q == '0) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Contents survive reset; only the write is suppressed so an abandoned push leaves no trace.
  always_ff @(posedge clk) begin
    if (we && !reset) mem_q[waddr] <= wdata;
  end

  assign top = mem_q[ptr_q];
  assign ptr = ptr_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
endmodule

// File: rtl/upc_seq.sv
// Microcycle state ring, microPC register and next-pc mux, with halt/single-step support.
module upc_seq
  import upc_pkg::*;
#(
  parameter int PC_W     = UPC_PC_W,
  parameter int SPC_LOG2 = UPC_SPC_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                jump,
  input  logic [PC_W-1:0]     jump_addr,
  input  logic                call,
  input  logic                ret,
  input  logic                disp,
  input  logic [PC_W-1:0]     disp_addr,
  input  logic                mem_busy,
  input  logic                halt,
  input  logic                step,
  output logic [PC_W-1:0]     pc,
  output logic                state_decode,
  output logic                state_read,
  output logic                state_alu,
  output logic                state_write,
  output logic                state_mmu,
  output logic                state_fetch,
  output logic                lpc_hold,
  output logic [SPC_LOG2-1:0] spc_ptr,
  output logic                spc_ovf,
  output logic                spc_unf
);
  upc_state_e      state_q, state_d;
  pc_src_e         src;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, spc_top;
  logic            step_pending_q, step_pending_d;
  logic            halted, advance, push, pop, swap;

  assign pc_inc  = pc_q + PC_W'(1);
  assign halted  = halt & ~step_pending_q;
  // Every pc and stack update happens on this single edge of the instruction.
  assign advance = (state_q == ST_FETCH) & ~halted;
  assign push    = advance & call & jump & ~ret;
  assign pop     = advance & ret & ~call;
  assign swap    = advance & ret & call;

  always_comb begin
    if (ret)       src = SRC_SPC;
    else if (disp) src = SRC_DISP;
    else if (jump) src = SRC_JUMP;
    else           src = SRC_INC;
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    step_pending_d = step_pending_q;
    unique case (state_q)
      ST_DECODE: state_d = ST_READ;
      ST_READ:   state_d = ST_ALU;
      ST_ALU:    state_d = ST_WRITE;
      ST_WRITE:  state_d = mem_busy ? ST_MMU : ST_FETCH;
      ST_MMU:    state_d = mem_busy ? ST_MMU : ST_FETCH;
      ST_FETCH:  if (!halted) state_d = ST_DECODE;
      default:   state_d = ST_DECODE;
    endcase
    if (advance) begin
      unique case (src)
        SRC_SPC:  pc_d = spc_top;
        SRC_DISP: pc_d = disp_addr;
        SRC_JUMP: pc_d = jump_addr;
        default:  pc_d = pc_inc;
      endcase
      step_pending_d = 1'b0;
    end
    if (step && halt) step_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_DECODE;
      pc_q           <= '0;
      step_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      step_pending_q <= step_pending_d;
    end
  end

  spc_stack #(.PC_W(PC_W), .SPC_LOG2(SPC_LOG2)) u_spc (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .swap  (swap),
    .wdata (pc_inc),
    .top   (spc_top),
    .ptr   (spc_ptr),
    .ovf   (spc_ovf),
    .unf   (spc_unf)
  );

  assign pc           = pc_q;
  assign state_decode = (state_q == ST_DECODE);
  assign state_read   = (state_q == ST_READ);
  assign state_alu    = (state_q == ST_ALU);
  assign state_write  = (state_q == ST_WRITE);
  assign state_mmu    = (state_q == ST_MMU);
  assign state_fetch  = (state_q == ST_FETCH);
  assign lpc_hold     = state_fetch & halted;
endmodule

// File: tb/tb_upc_seq.sv
// Self-checking bench for upc_seq: instruction-level reference model, directed and random steps.
module tb_upc_seq;
  localparam int PC_W = 14;
  localparam int SL2  = 5;
  localparam int S_DEC = 32'b100000, S_RD = 32'b010000, S_ALU = 32'b001000,
                 S_WR  = 32'b000100, S_MMU = 32'b000010, S_FE = 32'b000001;

  logic            clk = 1'b0, reset = 1'b0;
  logic            jump = 1'b0, call = 1'b0, ret = 1'b0, disp = 1'b0;
  logic            mem_busy = 1'b0, halt = 1'b0, step = 1'b0;
  logic [PC_W-1:0] jump_addr = '0, disp_addr = '0;
  logic [PC_W-1:0] pc;
  logic            state_decode, state_read, state_alu, state_write, state_mmu, state_fetch;
  logic            lpc_hold, spc_ovf, spc_unf;
  logic [SL2-1:0]  spc_ptr;

  upc_seq #(.PC_W(PC_W), .SPC_LOG2(SL2)) dut (
    .clk(clk), .reset(reset), .jump(jump), .jump_addr(jump_addr), .call(call), .ret(ret),
    .disp(disp), .disp_addr(disp_addr), .mem_busy(mem_busy), .halt(halt), .step(step),
    .pc(pc), .state_decode(state_decode), .state_read(state_read), .state_alu(state_alu),
    .state_write(state_write), .state_mmu(state_mmu), .state_fetch(state_fetch),
    .lpc_hold(lpc_hold), .spc_ptr(spc_ptr), .spc_ovf(spc_ovf), .spc_unf(spc_unf)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int m_pc = 0, m_ptr = 0, m_ovf = 0, m_unf = 0;
  int m_stk [32];

  function automatic int strobes();
    return 32'({state_decode, state_read, state_alu, state_write, state_mmu, state_fetch});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_pc"}, 32'(pc), m_pc);
    chk({tag, "_ptr"}, 32'(spc_ptr), m_ptr);
    chk({tag, "_ovf"}, 32'(spc_ovf), m_ovf);
    chk({tag, "_unf"}, 32'(spc_unf), m_unf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0; m_ptr = 0; m_ovf = 0; m_unf = 0;
    chk("rst_state", strobes(), S_DEC);
    chk("rst_lpc", 32'(lpc_hold), 0);
    chk_arch("rst");
  endtask

  // One instruction from DECODE through FETCH; nb = number of mmu wait cycles.
  task automatic exec(input bit j, input int ja, input bit c, input bit r, input bit d,
                      input int da, input int nb);
    int inc, np;
    jump = j; jump_addr = PC_W'(ja); call = c; ret = r; disp = d; disp_addr = PC_W'(da);
    chk("st_decode", strobes(), S_DEC); @(negedge clk);
    chk("st_read", strobes(), S_RD);    @(negedge clk);
    chk("st_alu", strobes(), S_ALU);    @(negedge clk);
    chk("st_write", strobes(), S_WR);
    mem_busy = (nb > 0);
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      chk("st_mmu", strobes(), S_MMU);
      mem_busy = (i < nb - 1);
      @(negedge clk);
    end
    chk("st_fetch", strobes(), S_FE);
    chk("fetch_pc", 32'(pc), m_pc);
    chk("fetch_lpc", 32'(lpc_hold), 0);
    inc = (m_pc + 1) % 16384;
    if (r)      np = m_stk[m_ptr];
    else if (d) np = da;
    else if (j) np = ja;
    else        np = inc;
    if (r && c) m_stk[m_ptr] = inc;
    else if (r) begin
      if (m_ptr == 0) m_unf = 1;
      m_ptr = (m_ptr + 31) % 32;
    end else if (c && j) begin
      m_ptr = (m_ptr + 1) % 32;
      if (m_ptr == 0) m_ovf = 1;
      m_stk[m_ptr] = inc;
    end
    m_pc = np;
    @(negedge clk);
    jump = 0; call = 0; ret = 0; disp = 0;
    chk_arch("next");
  endtask

  task automatic plain();
    exec(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int p, mode, nb;
    do_reset();
    for (int i = 0; i < 4; i++) plain();

    // wrap of pc+1 and an 8-cycle instruction
    exec(1, 16383, 0, 0, 0, 0, 0);
    plain();
    chk("wrap_pc", 32'(pc), 0);
    exec(0, 0, 0, 0, 0, 0, 3);

    // call / return / ret beats disp
    exec(1, 'h100, 0, 0, 0, 0, 0);
    exec(1, 'h200, 1, 0, 0, 0, 0);
    chk("call_pc", 32'(pc), 'h200);
    chk("call_ptr", 32'(spc_ptr), 1);
    exec(0, 0, 0, 1, 0, 0, 1);
    chk("ret_pc", 32'(pc), 'h101);
    exec(1, 'h200, 1, 0, 0, 0, 0);
    exec(0, 0, 0, 1, 1, 'h300, 0);
    chk("retdisp_pc", 32'(pc), 'h102);

    // 32 nested calls wrap the pointer and set overflow
    for (int i = 0; i < 32; i++) exec(1, $urandom_range(0, 16383), 1, 0, 0, 0, 0);
    chk("ovf_ptr", 32'(spc_ptr), 0);
    chk("ovf_flag", 32'(spc_ovf), 1);
    do_reset();
    exec(0, 0, 0, 1, 0, 0, 0);
    chk("unf_ptr", 32'(spc_ptr), 31);
    chk("unf_flag", 32'(spc_unf), 1);
    plain();
    do_reset();

    // swap: top=0x50 at pc=0x10
    exec(1, 'h4f, 0, 0, 0, 0, 0);
    exec(1, 'h10, 1, 0, 0, 0, 0);
    p = 32'(spc_ptr);
    exec(0, 0, 1, 1, 0, 0, 0);
    chk("swap_pc", 32'(pc), 'h50);
    chk("swap_ptr", 32'(spc_ptr), p);
    exec(0, 0, 0, 1, 0, 0, 0);
    chk("swap_top", 32'(pc), 'h11);

    // randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 6);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      case (mode)
        0: plain();
        1: exec(1, $urandom_range(0, 16383), 0, 0, 0, 0, nb);
        2: exec(1, $urandom_range(0, 16383), 1, 0, 0, 0, nb);
        3: exec(0, 0, 0, 1, 0, 0, nb);
        4: exec($urandom_range(0, 1), $urandom_range(0, 16383), 0, 0, 1,
                $urandom_range(0, 16383), nb);
        5: exec(0, 0, 1, 1, 0, 0, nb);
        default: exec(1, $urandom_range(0, 16383), 0, 1, $urandom_range(0, 1),
                      $urandom_range(0, 16383), nb);
      endcase
    end

    // halt parks in FETCH; one step runs exactly one instruction
    p = m_pc;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_state", strobes(), S_FE);
      chk("halt_pc", 32'(pc), p);
      chk("halt_lpc", 32'(lpc_hold), 1);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_fetch", strobes(), S_FE);
    chk("step_lpc", 32'(lpc_hold), 0);
    @(negedge clk);
    chk("step_decode", strobes(), S_DEC);
    chk("step_pc", 32'(pc), (p + 1) % 16384);
    for (int i = 0; i < 3; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("repark_state", strobes(), S_FE);
      chk("repark_pc", 32'(pc), (p + 1) % 16384);
      chk("repark_lpc", 32'(lpc_hold), 1);
    end
    halt = 1'b0;
    @(negedge clk);
    m_pc = (p + 2) % 16384;
    chk("resume_state", strobes(), S_DEC);
    chk_arch("resume");
    plain();

    // reset in the middle of an mmu wait
    for (int i = 0; i < 3; i++) @(negedge clk);
    mem_busy = 1'b1;
    @(negedge clk);
    chk("pre_rst_mmu", strobes(), S_MMU);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_busy = 1'b0;
    m_pc = 0; m_ptr = 0; m_ovf = 0; m_unf = 0;
    chk("mmu_rst_state", strobes(), S_DEC);
    chk_arch("mmu_rst");
    plain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
